vram_arbiter: RTL and testbench

Shares the single-port synchronous video/system RAM between the VGA glyph address generator (read-only, real-time) and the CPU (read/write, req/ack handshake). It sits between the `vga` block's `sys_addr`/`sys_data` pair and the RAM, and drives the RAM's only port. VGA fetches have fixed latency and priority. An optional starvation guard forces a CPU slot during long active-video bursts.

---
 rtl/vram_arbiter.sv | 141 ++++++++++++++
 tb/tb_vram_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the single port of the synchronous video/system RAM between the
//   VGA glyph fetcher (read-only, fixed 3-cycle latency, highest priority)
//   and the CPU (read/write, req/ack handshake, one access outstanding).
//
//   Optional build macro: VRAM_ARB_STARVE_GUARD_EN
//     defined   - a saturating 8-bit counter of denied CPU cycles forces a
//                 CPU slot once it reaches STARVE_LIMIT; the displaced VGA
//                 fetch is reported on vga_miss.
//     undefined - strict VGA priority, vga_miss is always 0.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   vga_req/vga_addr            VGA fetch request for this cycle
//   vga_data/vga_valid/vga_miss fetched word (3 cycles after request) / drop flag
//   cpu_req/we/addr/wdata       CPU request, held stable until cpu_ack
//   cpu_ack                     request accepted (cycle after grant)
//   cpu_rdata/cpu_rvalid        CPU read data (3 cycles after grant)
//   mem_addr/mem_wdata/mem_we   registered RAM port
//   mem_rdata                   RAM read data, one cycle after mem_addr
module vram_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic [DATA_WIDTH-1:0] vga_data,
    output logic                  vga_valid,
    output logic                  vga_miss,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {C_IDLE, C_ACK, C_RD1, C_RD2} cpu_state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU} tag_t;

    cpu_state_t state, state_nxt;
    tag_t       tag_s1, tag_s2;     // read destination, travels with the address
    logic [1:0] miss_pipe;          // dropped-VGA marker, aligned with the tags
    logic       cpu_idle, force_cpu, vga_grant, cpu_grant, vga_drop;

    assign cpu_idle = (state == C_IDLE);

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    logic [7:0] starve_cnt;

    assign force_cpu = cpu_req && cpu_idle && (starve_cnt >= LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (cpu_grant)
            starve_cnt <= '0;
        else if (cpu_req && cpu_idle && starve_cnt != 8'hFF)
            starve_cnt <= starve_cnt + 8'd1;
    end
`else
    assign force_cpu = 1'b0;
`endif

    assign vga_grant = vga_req && !force_cpu;
    assign cpu_grant = cpu_req && cpu_idle && (!vga_req || force_cpu);
    assign vga_drop  = vga_req && force_cpu;

    // cpu_ack is a pure state decode: the FSM sits in C_ACK exactly during N+1.
    assign cpu_ack = (state == C_ACK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= C_IDLE;
        else        state <= state_nxt;
    end

    // In C_ACK, mem_we still holds the granted access's direction.
    always_comb begin
        state_nxt = state;
        case (state)
            C_IDLE:  if (cpu_grant) state_nxt = C_ACK;
            C_ACK:   state_nxt = mem_we ? C_IDLE : C_RD1;
            C_RD1:   state_nxt = C_RD2;
            C_RD2:   state_nxt = C_IDLE;
            default: state_nxt = C_IDLE;
        endcase
    end

    // Issue stage: RAM port registers plus the first tag stage (cycle N+1).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            tag_s1    <= TAG_NONE;
        end else if (vga_grant) begin
            mem_addr  <= vga_addr;
            mem_we    <= 1'b0;
            tag_s1    <= TAG_VGA;
        end else if (cpu_grant) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_we    <= cpu_we;
            tag_s1    <= cpu_we ? TAG_NONE : TAG_CPU;
        end else begin
            mem_we    <= 1'b0;
            tag_s1    <= TAG_NONE;
        end
    end

    // RAM-data stage (N+2) and output capture (visible during N+3).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_s2     <= TAG_NONE;
            miss_pipe  <= '0;
            vga_data   <= '0;
            vga_valid  <= 1'b0;
            vga_miss   <= 1'b0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            tag_s2     <= tag_s1;
            miss_pipe  <= {miss_pipe[0], vga_drop};
            vga_miss   <= miss_pipe[1];
            vga_valid  <= (tag_s2 == TAG_VGA);
            cpu_rvalid <= (tag_s2 == TAG_CPU);
            if (tag_s2 == TAG_VGA) vga_data  <= mem_rdata;
            if (tag_s2 == TAG_CPU) cpu_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Directed bench for vram_arbiter with a behavioural synchronous RAM
//   (1-cycle read latency, initialised to ram[a] = a + 1). Inputs are driven
//   and outputs sampled on the falling edge; "cycle i" of a sequence is the
//   clock period containing the i-th falling edge of that sequence.
module tb_vram_arbiter;
    localparam int DW = 16;
    localparam int AW = 16;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int ACK_CYC  = 9;
    localparam int MISS_CYC = 11;
`else
    localparam int ACK_CYC  = 21;
    localparam int MISS_CYC = -1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_data;
    logic          vga_valid, vga_miss;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:65535];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
        .vga_valid(vga_valid), .vga_miss(vga_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 16'(a + 1);
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, ".vga_data"},   32'(vga_data),   0);
        chk({pfx, ".vga_valid"},  32'(vga_valid),  0);
        chk({pfx, ".vga_miss"},   32'(vga_miss),   0);
        chk({pfx, ".cpu_ack"},    32'(cpu_ack),    0);
        chk({pfx, ".cpu_rdata"},  32'(cpu_rdata),  0);
        chk({pfx, ".cpu_rvalid"}, 32'(cpu_rvalid), 0);
        chk({pfx, ".mem_addr"},   32'(mem_addr),   0);
        chk({pfx, ".mem_wdata"},  32'(mem_wdata),  0);
        chk({pfx, ".mem_we"},     32'(mem_we),     0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, rvs;

        // ---- reset state
        #2 chk_all_zero("rst");
        @(negedge clk) reset = 1'b1;

        // ---- CPU write 0x0040 <= 0xBEEF
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        chk("wr.ack",   32'(cpu_ack),   1);
        chk("wr.we",    32'(mem_we),    1);
        chk("wr.addr",  32'(mem_addr),  32'h0040);
        chk("wr.wdata", 32'(mem_wdata), 32'hBEEF);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        chk("wr.ack_off", 32'(cpu_ack), 0);
        chk("wr.we_off",  32'(mem_we),  0);

        // ---- CPU read 0x0040
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        @(negedge clk);
        chk("rd.ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd.rvalid_early", 32'(cpu_rvalid), 0);
        @(negedge clk);
        chk("rd.rvalid", 32'(cpu_rvalid), 1);
        chk("rd.rdata",  32'(cpu_rdata),  32'hBEEF);
        @(negedge clk);
        chk("rd.rvalid_off", 32'(cpu_rvalid), 0);

        // ---- VGA burst of 10 fetches, 0x100..0x109
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("burst.valid%0d", i), 32'(vga_valid), 32'(i >= 3 && i < 13));
            if (i >= 3 && i < 13)
                chk($sformatf("burst.data%0d", i), 32'(vga_data), 32'(16'h0101 + i - 3));
            vga_req  = (i < 10);
            vga_addr = 16'(16'h0100 + i);
        end
        vga_req = 1'b0;

        // ---- VGA held 20 cycles against a pending CPU read of 0x300
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            chk($sformatf("prio.ack%0d", i),  32'(cpu_ack),  32'(i == ACK_CYC));
            chk($sformatf("prio.miss%0d", i), 32'(vga_miss), 32'(i == MISS_CYC));
            chk($sformatf("prio.valid%0d", i), 32'(vga_valid),
                32'(i >= 3 && i <= 22 && i != MISS_CYC));
            if (i >= 3 && i <= 22 && i != MISS_CYC)
                chk($sformatf("prio.data%0d", i), 32'(vga_data), 32'(16'h0201 + i - 3));
            if (i == MISS_CYC)
                chk("prio.data_hold", 32'(vga_data), 32'(16'h0201 + i - 4));
            chk($sformatf("prio.rvalid%0d", i), 32'(cpu_rvalid), 32'(i == ACK_CYC + 2));
            if (i == ACK_CYC + 2)
                chk("prio.rdata", 32'(cpu_rdata), 32'h0301);
            vga_req  = (i < 20);
            vga_addr = 16'(16'h0200 + i);
            cpu_req  = (i < ACK_CYC);
            cpu_we   = 1'b0;
            cpu_addr = 16'h0300;
        end
        vga_req = 1'b0; cpu_req = 1'b0;

        // ---- CPU read with cpu_req held through ack and the read tail
        acks = 0; rvs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("hold.ack%0d", i), 32'(cpu_ack), 32'(i == 1));
            if (cpu_ack) acks++;
            if (cpu_rvalid) begin
                rvs++;
                chk("hold.rdata", 32'(cpu_rdata), 32'hBEEF);
            end
            cpu_req = (i < 4); cpu_we = 1'b0; cpu_addr = 16'h0040;
        end
        chk("hold.acks",   32'(acks), 1);
        chk("hold.rvalids", 32'(rvs), 1);

        // ---- reset asserted while the read is in C_RD1
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        @(negedge clk);
        chk("rrst.ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 chk_all_zero("rrst");
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rrst.rvalid%0d", i), 32'(cpu_rvalid), 0);
            chk($sformatf("rrst.vvalid%0d", i), 32'(vga_valid),  0);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0041; cpu_wdata = 16'h1234;
        @(negedge clk);
        chk("rrst.idle_ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
